// File: rtl/decode_queue.sv
// RV32I decode stage: fully decodes each fetched instruction and buffers the
// decoded records in an in-order queue between fetch and execute.
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_inst,
   input  logic [PC_W-1:0]              in_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PC_W-1:0]              out_pc,
   output logic [4:0]                   rs1,
   output logic [4:0]                   rs2,
   output logic [4:0]                   rd,
   output logic [2:0]                   funct3,
   output logic                         funct7_5,
   output logic [2:0]                   imm_type,
   output logic [31:0]                  imm,
   output logic                         is_lui,
   output logic                         is_auipc,
   output logic                         is_jal,
   output logic                         is_jalr,
   output logic                         is_branch,
   output logic                         is_load,
   output logic                         is_store,
   output logic                         is_opimm,
   output logic                         is_op,
   output logic                         illegal,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // cls bit order: lui, auipc, jal, jalr, branch, load, store, opimm, op
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic            funct7_5;
      logic [2:0]      imm_type;
      logic [31:0]     imm;
      logic [8:0]      cls;
      logic            illegal;
   } rec_t;

   rec_t          w_dec;
   rec_t          w_head;
   rec_t          w_out;
   rec_t          r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_enq;
   logic          w_deq;
   logic [31:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

   assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
   assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign w_imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign w_imm_u = {in_inst[31:12], 12'b0};
   assign w_imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

   always_comb begin
      w_dec          = '0;
      w_dec.pc       = in_pc;
      w_dec.rs1      = in_inst[19:15];
      w_dec.rs2      = in_inst[24:20];
      w_dec.rd       = in_inst[11:7];
      w_dec.funct3   = in_inst[14:12];
      w_dec.funct7_5 = in_inst[30];
      case (in_inst[6:0])
         7'b0110111: begin w_dec.cls = 9'b100000000; w_dec.imm_type = 3'b100; w_dec.imm = w_imm_u; end
         7'b0010111: begin w_dec.cls = 9'b010000000; w_dec.imm_type = 3'b100; w_dec.imm = w_imm_u; end
         7'b1101111: begin w_dec.cls = 9'b001000000; w_dec.imm_type = 3'b101; w_dec.imm = w_imm_j; end
         7'b1100111: begin w_dec.cls = 9'b000100000; w_dec.imm_type = 3'b001; w_dec.imm = w_imm_i; end
         7'b1100011: begin w_dec.cls = 9'b000010000; w_dec.imm_type = 3'b011; w_dec.imm = w_imm_b; end
         7'b0000011: begin w_dec.cls = 9'b000001000; w_dec.imm_type = 3'b001; w_dec.imm = w_imm_i; end
         7'b0100011: begin w_dec.cls = 9'b000000100; w_dec.imm_type = 3'b010; w_dec.imm = w_imm_s; end
         7'b0010011: begin w_dec.cls = 9'b000000010; w_dec.imm_type = 3'b001; w_dec.imm = w_imm_i; end
         7'b0110011: begin w_dec.cls = 9'b000000001; end
         default:    begin w_dec.illegal = 1'b1; end
      endcase
   end

   // Handshake status comes only from the registered count; no full-queue bypass.
   assign in_ready  = (r_count < CW'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_enq     = in_valid && in_ready;
   assign w_deq     = out_valid && out_ready;
   assign count     = r_count;

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem[r_wr_ptr] <= w_dec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head = r_mem[r_rd_ptr];
   assign w_out  = out_valid ? w_head : '0;

   assign out_pc    = w_out.pc;
   assign rs1       = w_out.rs1;
   assign rs2       = w_out.rs2;
   assign rd        = w_out.rd;
   assign funct3    = w_out.funct3;
   assign funct7_5  = w_out.funct7_5;
   assign imm_type  = w_out.imm_type;
   assign imm       = w_out.imm;
   assign is_lui    = w_out.cls[8];
   assign is_auipc  = w_out.cls[7];
   assign is_jal    = w_out.cls[6];
   assign is_jalr   = w_out.cls[5];
   assign is_branch = w_out.cls[4];
   assign is_load   = w_out.cls[3];
   assign is_store  = w_out.cls[2];
   assign is_opimm  = w_out.cls[1];
   assign is_op     = w_out.cls[0];
   assign illegal   = w_out.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH=4, PC_W=32).
module tb_decode_queue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_inst = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic [2:0]  imm_type;
   logic [31:0] imm;
   logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
   logic        illegal;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;

   wire [8:0] cls = {is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op};

   always #5 clk = ~clk;

   decode_queue #(.DEPTH(4), .PC_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .funct7_5(funct7_5),
      .imm_type(imm_type), .imm(imm),
      .is_lui(is_lui), .is_auipc(is_auipc), .is_jal(is_jal), .is_jalr(is_jalr),
      .is_branch(is_branch), .is_load(is_load), .is_store(is_store),
      .is_opimm(is_opimm), .is_op(is_op), .illegal(illegal), .count(count)
   );

   // Drive one enqueue across a single rising edge; called just after a negedge.
   task automatic enq_one(input logic [31:0] inst, input logic [31:0] pc);
      in_valid = 1'b1; in_inst = inst; in_pc = pc;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain_all();
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0 || out_pc !== 32'd0 || imm !== 32'd0 || cls !== 9'd0) begin
         n_errors++;
         $display("FAIL reset: out_valid=%b in_ready=%b count=%0d out_pc=%h imm=%h cls=%b, required 0 1 0 0 0 0",
                  out_valid, in_ready, count, out_pc, imm, cls);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      enq_one(32'hFFF00093, 32'h100);
      n_checks++;
      if (out_valid !== 1'b1 || is_opimm !== 1'b1 || imm_type !== 3'b001 || imm !== 32'hFFFFFFFF || rd !== 5'd1 || out_pc !== 32'h100 || cls !== 9'b000000010) begin
         n_errors++;
         $display("FAIL single_addi: valid=%b opimm=%b type=%b imm=%h rd=%0d pc=%h cls=%b, required 1 1 001 ffffffff 1 100 000000010",
                  out_valid, is_opimm, imm_type, imm, rd, out_pc, cls);
      end
      drain_all();
   endtask

   task automatic test_formats();
      logic [31:0] t_inst [5] = '{32'h00112223, 32'hFE000EE3, 32'h123450B7, 32'h0080006F, 32'h0000007F};
      logic [2:0]  t_type [5] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b000};
      logic [31:0] t_imm  [5] = '{32'd4, 32'hFFFFFFFC, 32'h12345000, 32'd8, 32'd0};
      logic [8:0]  t_cls  [5] = '{9'b000000100, 9'b000010000, 9'b100000000, 9'b001000000, 9'b000000000};
      logic        t_ill  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 5; k++) begin
         enq_one(t_inst[k], 32'h40 + 32'(k));
         n_checks++;
         if (out_valid !== 1'b1 || imm_type !== t_type[k] || imm !== t_imm[k] || cls !== t_cls[k] || illegal !== t_ill[k]) begin
            n_errors++;
            $display("FAIL format_%0d inst=%h: valid=%b type=%b imm=%h cls=%b illegal=%b, required 1 %b %h %b %b",
                     k, t_inst[k], out_valid, imm_type, imm, cls, illegal, t_type[k], t_imm[k], t_cls[k], t_ill[k]);
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
      // Field extraction on the store: rs1=2, rs2=1, funct3=2
      enq_one(32'h00112223, 32'h80);
      n_checks++;
      if (rs1 !== 5'd2 || rs2 !== 5'd1 || funct3 !== 3'd2 || funct7_5 !== 1'b0) begin
         n_errors++;
         $display("FAIL fields_sw: rs1=%0d rs2=%0d f3=%0d f7_5=%b, required 2 1 2 0", rs1, rs2, funct3, funct7_5);
      end
      drain_all();
   endtask

   task automatic test_fill_backpressure();
      for (int k = 0; k < 4; k++) enq_one(32'h00000013, 32'(4 * k));
      n_checks++;
      if (count !== 3'd4 || in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL fill: count=%0d in_ready=%b, required 4 0", count, in_ready);
      end
      enq_one(32'h00000013, 32'h10);
      n_checks++;
      if (count !== 3'd4 || out_pc !== 32'h0) begin
         n_errors++;
         $display("FAIL held_off: count=%0d head_pc=%h, required 4 0", count, out_pc);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
            n_errors++;
            $display("FAIL drain_%0d: valid=%b pc=%h, required 1 %h", k, out_valid, out_pc, 32'(4 * k));
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         n_errors++;
         $display("FAIL drained_empty: valid=%b count=%0d, required 0 0", out_valid, count);
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h00000013;
      for (int k = 0; k < 10; k++) begin
         in_pc = 32'h200 + 32'(4 * k);
         @(negedge clk);
         n_checks++;
         if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(4 * k)) begin
            n_errors++;
            $display("FAIL stream_%0d: count=%0d valid=%b pc=%h, required 1 1 %h",
                     k, count, out_valid, out_pc, 32'h200 + 32'(4 * k));
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (count !== 3'd0) begin
         n_errors++;
         $display("FAIL stream_end: count=%0d, required 0", count);
      end
   endtask

   task automatic test_flush();
      for (int k = 0; k < 3; k++) enq_one(32'h00000013, 32'h300 + 32'(4 * k));
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h999; in_inst = 32'h00000013;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      n_checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'd0) begin
         n_errors++;
         $display("FAIL flush: count=%0d valid=%b in_ready=%b pc=%h, required 0 0 1 0", count, out_valid, in_ready, out_pc);
      end
      @(negedge clk);
      n_checks++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_dropped: count=%0d valid=%b, required 0 0", count, out_valid);
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 3; k++) enq_one(32'hFFF00093, 32'h400 + 32'(4 * k));
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || out_pc !== 32'd0 || imm !== 32'd0 || rd !== 5'd0 || cls !== 9'd0) begin
         n_errors++;
         $display("FAIL async_reset: valid=%b count=%0d in_ready=%b pc=%h imm=%h rd=%0d cls=%b, required 0 0 1 0 0 0 0",
                  out_valid, count, in_ready, out_pc, imm, rd, cls);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      enq_one(32'h0080006F, 32'h500);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h500 || count !== 3'd1) begin
         n_errors++;
         $display("FAIL post_reset_enq: valid=%b pc=%h count=%0d, required 1 500 1", out_valid, out_pc, count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_formats();
      test_fill_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
# decode_queue

Registered RV32I decode stage with an instruction queue between fetch and execute. It accepts `{inst, pc}` from fetch over a valid/ready handshake and fully decodes each instruction before storing it: register fields, class flags, immediate type and sign-extended immediate for all base formats. It then presents entries in order to execute over a second valid/ready handshake. It supersedes the purely combinational decoder: the immediate type is derived internally from the opcode, U/J formats are supported, illegal opcodes are flagged, and a synchronous flush handles branch redirects.

## Interface
- `DEPTH`, default 4: queue entries; power of two, ≥ 2.
- `PC_W`, default 32: PC width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous queue clear (redirect).
- `in_valid` in 1: fetch offers an instruction.
- `in_ready` out 1: queue can accept.
- `in_inst` in 32: instruction word.
- `in_pc` in PC_W: instruction address.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: execute consumes head.
- `out_pc` out PC_W: head PC.
- `rs1`, `rs2`, `rd` out 5 each: raw fields `inst[19:15]`, `inst[24:20]`, `inst[11:7]`.
- `funct3` out 3: `inst[14:12]`.
- `funct7_5` out 1: `inst[30]`.
- `imm_type` out 3: 000 none, 001 I, 010 S, 011 B, 100 U, 101 J.
- `imm` out 32: decoded immediate.
- `is_lui`, `is_auipc`, `is_jal`, `is_jalr`, `is_branch`, `is_load`, `is_store`, `is_opimm`, `is_op` out 1 each: one-hot class flags.
- `illegal` out 1: unrecognised opcode.
- `count` out $clog2(DEPTH+1): occupied entries.

## Operation
- Opcode `inst[6:0]` classes:
  - 0110111 LUI (U)
  - 0010111 AUIPC (U)
  - 1101111 JAL (J)
  - 1100111 JALR (I)
  - 1100011 BRANCH (B)
  - 0000011 LOAD (I)
  - 0100011 STORE (S)
  - 0010011 OP-IMM (I)
  - 0110011 OP (none)
- Any other opcode: `illegal`=1, all class flags 0, `imm_type`=000, `imm`=0. The entry is still enqueued.
- Immediates, all sign-extended from `inst[31]`:
  - I: `inst[31:20]`.
  - S: `{inst[31:25], inst[11:7]}`.
  - B: `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`.
  - U: `{inst[31:12], 12'b0}`.
  - J: `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`.
  - none: 0.
- Decode is combinational on `in_inst`. The decoded record is written into the queue at the tail on enqueue.
- Enqueue when `in_valid && in_ready`. Dequeue when `out_valid && out_ready`.
- `in_ready` = (`count` < `DEPTH`). There is no full-queue bypass: a full queue deasserts `in_ready` even if a dequeue occurs the same cycle.
- `out_valid` = (`count` != 0).
- When `out_valid`=0, all payload outputs (`out_pc` … `illegal`) are driven 0.
- Simultaneous enqueue and dequeue: `count` unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally.
- `flush`=1 at an edge sets pointers and `count` to 0. It overrides any enqueue or dequeue in that cycle; an instruction handshaked during a flush cycle is discarded.
- Reset (`rst_n`=0, asynchronous) forces pointers and `count` to 0, so `out_valid`=0, `in_ready`=1, and all payload outputs are 0. Storage contents are not reset.
- Reset asserted mid-stream drops all entries immediately, without waiting for a clock edge.

## Timing
- Enqueue-to-`out_valid` latency: 1 cycle. An instruction accepted at edge N is presentable after edge N, with no same-cycle pass-through.
- Sustained throughput: 1 instruction/cycle when not full.
- Head outputs are register/memory read by read pointer. They change only at a clock edge or on asynchronous reset.
- `in_ready` and `out_valid` depend only on registered state, with no combinational path from `out_ready` or `in_valid`.
- `flush` takes effect at the next rising edge: `out_valid`=0 and `in_ready`=1 in the following cycle.

## Test plan
- Reset then single enqueue: `in_inst`=0xFFF00093 (addi x1,x0,-1), pc=0x100. Next cycle: `out_valid`=1, `is_opimm`=1, `imm_type`=001, `imm`=0xFFFFFFFF, `rd`=1, `out_pc`=0x100.
- Format sweep, one check per format:
  - 0x00112223 (sw) → S, `imm`=4.
  - 0xFE000EE3 (beq offset -4) → B, `imm`=0xFFFFFFFC.
  - 0x123450B7 (lui) → U, `imm`=0x12345000.
  - 0x0080006F (jal +8) → J, `imm`=8.
- Illegal: `in_inst`=0x0000007F → `illegal`=1, all class flags 0, `imm`=0.
- Fill and back-pressure with DEPTH=4, `out_ready`=0:
  - 4 enqueues → `count`=4, `in_ready`=0.
  - A 5th `in_valid` is held off.
  - Raising `out_ready` drains the entries in order, with pc 0,4,8,12.
- Streaming with wrap-around: `in_valid`=`out_ready`=1 for 10 cycles. `count` stays 1 after the first edge, output order matches input order, and pointers wrap without loss.
- Flush and reset:
  - With 3 entries queued, `flush` for 1 cycle while `in_valid`=1 → next cycle `count`=0 and `out_valid`=0; the concurrent instruction is dropped.
  - Repeat with `rst_n` pulsed low between edges → outputs are 0 immediately.
